// File: rtl/tdc_multi_core.sv
// Multi-channel TDC: shared START, NUM_CH STOPs, coarse count on clk plus a per-channel delay-line fine code.
// Results drain in channel order on a valid/ready stream whose outputs are registered and held while stalled.
module tdc_multi_core #(
    parameter int NUM_CH      = 4,
    parameter int COARSE_W    = 28,
    parameter int FINE_W      = 6,
    parameter int SYNC_STAGES = 3,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_in,
    input  logic [NUM_CH-1:0]          stop_in,
    input  logic                       arm,
    input  logic                       continuous,
    input  logic [COARSE_W-1:0]        timeout_cycles,
    input  logic [NUM_CH*FINE_W-1:0]   fine_code,
    output logic [NUM_CH-1:0]          sample,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [COARSE_W+FINE_W-1:0] res_data,
    output logic [CH_W-1:0]            res_ch,
    output logic                       res_timeout,
    output logic                       busy,
    output logic [2:0]                 state_out
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        MEASURING = 3'd2,
        SETTLE    = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    state_t                     state_q;
    logic [SYNC_STAGES-1:0]     start_sync_q;
    logic                       start_prev_q;
    logic [NUM_CH-1:0]          stop_sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]          stop_prev_q;
    logic [COARSE_W-1:0]        cnt_q;
    logic [COARSE_W-1:0]        tmo_q;
    logic [NUM_CH-1:0]          hit_q;
    logic [NUM_CH-1:0]          sample_q;
    logic [COARSE_W-1:0]        coarse_q [NUM_CH];
    logic [FINE_W-1:0]          fine_q [NUM_CH];
    logic [CH_W-1:0]            idx_q;
    logic                       res_valid_q;
    logic [COARSE_W+FINE_W-1:0] res_data_q;
    logic [CH_W-1:0]            res_ch_q;
    logic                       res_timeout_q;

    logic                       start_rise;
    logic [NUM_CH-1:0]          stop_rise;
    logic [NUM_CH-1:0]          new_hit;
    logic [NUM_CH-1:0]          hit_d;
    logic                       last_idx;
    logic [CH_W-1:0]            sel_idx;
    logic [COARSE_W+FINE_W-1:0] sel_data;
    logic                       sel_timeout;

    always_comb begin
        start_rise  = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
        stop_rise   = stop_sync_q[SYNC_STAGES-1] & ~stop_prev_q;
        new_hit     = (state_q == MEASURING) ? (stop_rise & ~hit_q) : '0;
        hit_d       = hit_q | new_hit;
        last_idx    = (idx_q == CH_W'(NUM_CH - 1));
        // Once a result is showing, prepare the next one so a transfer is followed without a bubble.
        sel_idx     = (res_valid_q && !last_idx) ? idx_q + 1'b1 : idx_q;
        sel_data    = {tmo_q, {FINE_W{1'b0}}};
        sel_timeout = 1'b1;
        for (int j = 0; j < NUM_CH; j++) begin
            if (sel_idx == CH_W'(j) && hit_q[j]) begin
                sel_data    = {coarse_q[j], fine_q[j]};
                sel_timeout = 1'b0;
            end
        end
    end

    assign sample      = new_hit;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign res_timeout = res_timeout_q;
    assign busy        = (state_q != IDLE);
    assign state_out   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            start_sync_q  <= '0;
            start_prev_q  <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) stop_sync_q[s] <= '0;
            stop_prev_q   <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            hit_q         <= '0;
            sample_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                coarse_q[i] <= '0;
                fine_q[i]   <= '0;
            end
            idx_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_ch_q      <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start_in};
            start_prev_q <= start_sync_q[SYNC_STAGES-1];
            stop_sync_q[0] <= stop_in;
            for (int s = 1; s < SYNC_STAGES; s++) stop_sync_q[s] <= stop_sync_q[s-1];
            stop_prev_q  <= stop_sync_q[SYNC_STAGES-1];

            // Delay-line code is valid exactly one cycle after its sample strobe.
            sample_q <= new_hit;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sample_q[i]) fine_q[i] <= fine_code[i*FINE_W +: FINE_W];
            end

            case (state_q)
                IDLE: begin
                    if (arm) state_q <= ARMED;
                end
                ARMED: begin
                    hit_q <= '0;
                    if (start_rise) begin
                        cnt_q   <= {{(COARSE_W-1){1'b0}}, 1'b1};
                        tmo_q   <= (timeout_cycles == '0) ? '1 : timeout_cycles;
                        state_q <= MEASURING;
                    end
                end
                MEASURING: begin
                    hit_q <= hit_d;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (new_hit[i]) coarse_q[i] <= cnt_q;
                    end
                    if ((&hit_d) || (cnt_q == tmo_q)) begin
                        state_q <= SETTLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    idx_q       <= '0;
                    res_valid_q <= 1'b0;
                    state_q     <= DRAIN;
                end
                DRAIN: begin
                    if (!res_valid_q) begin
                        res_valid_q   <= 1'b1;
                        res_data_q    <= sel_data;
                        res_ch_q      <= sel_idx;
                        res_timeout_q <= sel_timeout;
                    end else if (res_ready) begin
                        if (last_idx) begin
                            res_valid_q <= 1'b0;
                            if (continuous) state_q <= ARMED;
                            else            state_q <= IDLE;
                        end else begin
                            idx_q         <= sel_idx;
                            res_data_q    <= sel_data;
                            res_ch_q      <= sel_idx;
                            res_timeout_q <= sel_timeout;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
